// File: rtl/proc_test_pkg.sv
// proc_test_pkg: shared types and constants for the end-of-test monitor.
//   tm_state_t    - monitor FSM states (run plus three absorbing outcomes)
//   trace_entry_t - one register writeback as seen by a trace consumer
//   TOHOST_PASS   - tohost value that means "test passed"
//   is_terminal() - true for any state that ends the test
package proc_test_pkg;

  localparam int unsigned TM_XLEN     = 32;
  localparam int unsigned TOHOST_PASS = 32'd1;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_PASS    = 2'd1,
    ST_FAIL    = 2'd2,
    ST_TIMEOUT = 2'd3
  } tm_state_t;

  typedef struct packed {
    logic [4:0]         addr;
    logic [TM_XLEN-1:0] data;
  } trace_entry_t;

  function automatic logic is_terminal(input tm_state_t s);
    return (s != ST_RUN);
  endfunction

endpackage

// File: rtl/proc_test_monitor_trace_fifo.sv
// trace_fifo: synchronous FIFO with a registered head entry.
//   push/push_data      - write request; dropped (and overflow set) when full
//                         unless a pop happens in the same cycle
//   out_valid/out_data  - registered head entry, no fall-through
//   pop_ready           - consumer accepts the head when out_valid is high
//   overflow            - sticky, at least one push was dropped
// Pointers carry one extra wrap bit so full/empty are told apart by the MSB.
module trace_fifo #(
  parameter int unsigned WIDTH = 37,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [PW-1:0]    wr_ptr_nxt_s;
  logic [PW-1:0]    rd_ptr_nxt_s;
  logic             empty_s;
  logic             full_s;
  logic             pop_s;
  logic             wr_en_s;
  logic             drop_s;
  logic             valid_nxt_s;
  logic [WIDTH-1:0] head_nxt_s;

  // Occupancy decode, pointer advance and next head entry.
  always_comb begin
    empty_s      = (wr_ptr_r == rd_ptr_r);
    full_s       = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                   (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    pop_s        = out_valid && pop_ready;
    wr_en_s      = push && (!full_s || pop_s);
    drop_s       = push && full_s && !pop_s;
    wr_ptr_nxt_s = wr_ptr_r;
    rd_ptr_nxt_s = rd_ptr_r;
    head_nxt_s   = '0;
    if (wr_en_s) begin
      wr_ptr_nxt_s = wr_ptr_r + PW'(1'b1);
    end else begin
      wr_ptr_nxt_s = wr_ptr_r;
    end
    if (pop_s) begin
      rd_ptr_nxt_s = rd_ptr_r + PW'(1'b1);
    end else begin
      rd_ptr_nxt_s = rd_ptr_r;
    end
    valid_nxt_s = (wr_ptr_nxt_s != rd_ptr_nxt_s);
    // The slot being written this cycle becomes the head only when the FIFO
    // holds exactly that one entry afterwards, so bypass the array for it.
    if (!valid_nxt_s) begin
      head_nxt_s = '0;
    end else if (wr_en_s && (wr_ptr_r[AW-1:0] == rd_ptr_nxt_s[AW-1:0])) begin
      head_nxt_s = push_data;
    end else begin
      head_nxt_s = mem_r[rd_ptr_nxt_s[AW-1:0]];
    end
  end

  // Storage array; pointer reset alone empties it, so data needs no reset.
  always_ff @(posedge clk) begin
    if (!rst && wr_en_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= push_data;
    end
  end

  // Pointers, registered head entry and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r  <= '0;
      rd_ptr_r  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      overflow  <= 1'b0;
    end else begin
      wr_ptr_r  <= wr_ptr_nxt_s;
      rd_ptr_r  <= rd_ptr_nxt_s;
      out_valid <= valid_nxt_s;
      out_data  <= head_nxt_s;
      overflow  <= overflow | drop_s;
    end
  end

endmodule

// File: rtl/proc_test_monitor.sv
// proc_test_monitor: decides pass/fail/timeout for a processor test run.
//   clk, rst                       - clock, synchronous active-high reset
//   rf_we/rf_waddr/rf_wdata        - snooped register-file write port
//   dm_we/dm_addr/dm_wdata         - snooped data-memory write port (tohost)
//   retire                         - one instruction completed
//   done/pass/fail/timeout         - sticky outcome flags
//   fail_code                      - tohost value >> 1 on fail
//   cycle_count/retired_count      - run cycles and retired instructions
//   watch_value                    - shadow copies of selected registers
//   trace_valid/ready/addr/data    - writeback trace stream (ready/valid)
//   trace_overflow                 - sticky, a trace entry was dropped
module proc_test_monitor
  import proc_test_pkg::*;
#(
  parameter int unsigned             XLEN           = 32,
  parameter logic [XLEN-1:0]         TOHOST_ADDR    = 32'h0000_0FF0,
  parameter int unsigned             TIMEOUT_CYCLES = 5000,
  parameter int unsigned             NUM_WATCH      = 3,
  parameter logic [NUM_WATCH*5-1:0]  WATCH_IDX      = {5'd2, 5'd4, 5'd3},
  parameter int unsigned             TRACE_DEPTH    = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rf_we,
  input  logic [4:0]                rf_waddr,
  input  logic [XLEN-1:0]           rf_wdata,
  input  logic                      dm_we,
  input  logic [XLEN-1:0]           dm_addr,
  input  logic [XLEN-1:0]           dm_wdata,
  input  logic                      retire,
  output logic                      done,
  output logic                      pass,
  output logic                      fail,
  output logic                      timeout,
  output logic [XLEN-1:0]           fail_code,
  output logic [31:0]               cycle_count,
  output logic [31:0]               retired_count,
  output logic [NUM_WATCH*XLEN-1:0] watch_value,
  output logic                      trace_valid,
  input  logic                      trace_ready,
  output logic [4:0]                trace_addr,
  output logic [XLEN-1:0]           trace_data,
  output logic                      trace_overflow
);

  tm_state_t         state_r;
  tm_state_t         state_nxt_s;
  logic              tohost_hit_s;
  logic              last_cycle_s;
  logic              trace_push_s;
  logic [XLEN-1:0]   watch_r [NUM_WATCH];
  logic [XLEN+4:0]   trace_out_s;

  // Outcome decision; a tohost store outranks the timeout in the same cycle.
  always_comb begin
    tohost_hit_s = dm_we && (dm_addr == TOHOST_ADDR);
    last_cycle_s = (cycle_count == 32'(TIMEOUT_CYCLES - 1));
    state_nxt_s  = state_r;
    case (state_r)
      ST_RUN: begin
        if (tohost_hit_s) begin
          if (dm_wdata == XLEN'(TOHOST_PASS)) begin
            state_nxt_s = ST_PASS;
          end else begin
            state_nxt_s = ST_FAIL;
          end
        end else if (last_cycle_s) begin
          state_nxt_s = ST_TIMEOUT;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_PASS, ST_FAIL, ST_TIMEOUT: state_nxt_s = state_r;
      default:                      state_nxt_s = ST_RUN;
    endcase
  end

  // State register and registered outcome flags (absorbing, hence sticky).
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_RUN;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail      <= 1'b0;
      timeout   <= 1'b0;
      fail_code <= '0;
    end else begin
      state_r <= state_nxt_s;
      done    <= is_terminal(state_nxt_s);
      pass    <= (state_nxt_s == ST_PASS);
      fail    <= (state_nxt_s == ST_FAIL);
      timeout <= (state_nxt_s == ST_TIMEOUT);
      if ((state_r == ST_RUN) && (state_nxt_s == ST_FAIL)) begin
        fail_code <= dm_wdata >> 1;
      end
    end
  end

  // Run-time counters; both freeze once the test has an outcome.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_count   <= 32'd0;
      retired_count <= 32'd0;
    end else if (state_r == ST_RUN) begin
      cycle_count <= cycle_count + 32'd1;
      if (retire && (retired_count != 32'hFFFF_FFFF)) begin
        retired_count <= retired_count + 32'd1;
      end
    end
  end

  // Shadow registers; they keep tracking after the test ends.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_WATCH; k++) begin
        watch_r[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_WATCH; k++) begin
        if (rf_we && (rf_waddr != 5'd0) && (rf_waddr == WATCH_IDX[k*5 +: 5])) begin
          watch_r[k] <= rf_wdata;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_WATCH; g++) begin : g_watch
    assign watch_value[g*XLEN +: XLEN] = watch_r[g];
  end

  assign trace_push_s = rf_we && (rf_waddr != 5'd0) && (state_r == ST_RUN);

  trace_fifo #(
    .WIDTH (XLEN + 5),
    .DEPTH (TRACE_DEPTH)
  ) u_trace_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (trace_push_s),
    .push_data ({rf_waddr, rf_wdata}),
    .pop_ready (trace_ready),
    .out_valid (trace_valid),
    .out_data  (trace_out_s),
    .overflow  (trace_overflow)
  );

  assign trace_addr = trace_out_s[XLEN +: 5];
  assign trace_data = trace_out_s[XLEN-1:0];

endmodule

// File: tb/tb_proc_test_monitor.sv
module tb_proc_test_monitor;
  import proc_test_pkg::*;

  localparam int          XL    = 32;
  localparam int          TO    = 40;
  localparam int          NW    = 3;
  localparam int          DEPTH = 8;
  localparam logic [14:0] WIDX  = {5'd2, 5'd4, 5'd3};
  localparam logic [31:0] TH    = 32'h0000_0FF0;

  logic           clk = 1'b0;
  logic           rst;
  logic           rf_we;
  logic [4:0]     rf_waddr;
  logic [XL-1:0]  rf_wdata;
  logic           dm_we;
  logic [XL-1:0]  dm_addr;
  logic [XL-1:0]  dm_wdata;
  logic           retire;
  logic           done, pass, fail, timeout;
  logic [XL-1:0]  fail_code;
  logic [31:0]    cycle_count, retired_count;
  logic [NW*XL-1:0] watch_value;
  logic           trace_valid, trace_ready, trace_overflow;
  logic [4:0]     trace_addr;
  logic [XL-1:0]  trace_data;

  always #5 clk = ~clk;

  proc_test_monitor #(
    .XLEN(XL), .TOHOST_ADDR(TH), .TIMEOUT_CYCLES(TO),
    .NUM_WATCH(NW), .WATCH_IDX(WIDX), .TRACE_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .retire(retire),
    .done(done), .pass(pass), .fail(fail), .timeout(timeout), .fail_code(fail_code),
    .cycle_count(cycle_count), .retired_count(retired_count), .watch_value(watch_value),
    .trace_valid(trace_valid), .trace_ready(trace_ready), .trace_addr(trace_addr),
    .trace_data(trace_data), .trace_overflow(trace_overflow)
  );

  // Reference model: outcome 0=running 1=passed 2=failed 3=timed out.
  int             m_outcome;
  logic [31:0]    m_cycles, m_retired, m_fail_code;
  logic [XL-1:0]  m_watch [NW];
  logic           m_ovf;
  trace_entry_t   exp_q [$];
  int             pushed_now;
  int             n_checks, n_err;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic int chan_of(input logic [4:0] r);
    logic [14:0] w;
    w = WIDX;
    for (int k = 0; k < NW; k++) if (w[k*5 +: 5] == r) return k;
    return -1;
  endfunction

  // Predict the effect of the coming clock edge from the inputs now applied.
  task automatic model_update();
    bit pop;
    int ch;
    pushed_now = 0;
    if (rst) begin
      m_outcome = 0; m_cycles = 0; m_retired = 0; m_fail_code = 0; m_ovf = 0;
      for (int k = 0; k < NW; k++) m_watch[k] = '0;
      exp_q.delete();
    end else begin
      pop = trace_ready && (exp_q.size() > 0);
      if (rf_we && rf_waddr != 5'd0) begin
        ch = chan_of(rf_waddr);
        if (ch >= 0) m_watch[ch] = rf_wdata;
        if (m_outcome == 0) begin
          if (exp_q.size() < DEPTH || pop) begin
            exp_q.push_back('{addr: rf_waddr, data: rf_wdata});
            pushed_now = 1;
          end else begin
            m_ovf = 1'b1;
          end
        end
      end
      if (m_outcome == 0) begin
        if (dm_we && dm_addr == TH) begin
          if (dm_wdata == 32'd1) m_outcome = 1;
          else begin m_outcome = 2; m_fail_code = dm_wdata / 2; end
        end else if (m_cycles == TO - 1) begin
          m_outcome = 3;
        end
        m_cycles = m_cycles + 1;
        if (retire && m_retired != 32'hFFFF_FFFF) m_retired = m_retired + 1;
      end
    end
  endtask

  task automatic check_status();
    chk("done", done, m_outcome != 0);
    chk("pass", pass, m_outcome == 1);
    chk("fail", fail, m_outcome == 2);
    chk("timeout", timeout, m_outcome == 3);
    chk("fail_code", fail_code, m_fail_code);
    chk("cycle_count", cycle_count, m_cycles);
    chk("retired_count", retired_count, m_retired);
    chk("trace_overflow", trace_overflow, m_ovf);
    chk("watch_value", watch_value, {m_watch[2], m_watch[1], m_watch[0]});
  endtask

  task automatic step();
    model_update();
    @(posedge clk);
    #1;
    check_status();
  endtask

  // Scoreboard side: compares every accepted trace entry with the model queue.
  task automatic monitor_loop();
    trace_entry_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("trace_valid", trace_valid, (exp_q.size() - pushed_now) > 0);
        if (trace_valid && trace_ready) begin
          if (exp_q.size() == 0) begin
            chk("trace_unexpected", 1'b1, 1'b0);
          end else begin
            e = exp_q.pop_front();
            chk("trace_addr", trace_addr, e.addr);
            chk("trace_data", trace_data, e.data);
          end
        end
      end
    end
  endtask

  task automatic idle();
    rf_we = 0; rf_waddr = 0; rf_wdata = 0; dm_we = 0; dm_addr = 0; dm_wdata = 0; retire = 0;
  endtask

  task automatic rnd_inputs(input bit allow_tohost);
    int sel;
    rf_we = 1'($urandom_range(0, 1));
    sel = $urandom_range(0, 7);
    case (sel)
      0: rf_waddr = 5'd0;
      1: rf_waddr = 5'd2;
      2: rf_waddr = 5'd3;
      3: rf_waddr = 5'd4;
      default: rf_waddr = 5'($urandom_range(0, 31));
    endcase
    rf_wdata = $urandom;
    dm_we    = 1'($urandom_range(0, 1));
    dm_addr  = $urandom;
    if (dm_addr == TH) dm_addr = dm_addr ^ 32'h4;
    if (allow_tohost && $urandom_range(0, 24) == 0) dm_addr = TH;
    dm_wdata = ($urandom_range(0, 1) == 1) ? 32'd1 : $urandom;
    retire = 1'($urandom_range(0, 1));
    trace_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    step();
    rst = 0;
  endtask

  initial begin
    n_checks = 0; n_err = 0; pushed_now = 0;
    trace_ready = 0;
    fork monitor_loop(); join_none
    do_reset();
    chk("reset_valid", trace_valid, 1'b0);

    // Pass: x3=5 early, tohost=1 at cycle 20.
    for (int c = 0; c < 26; c++) begin
      rnd_inputs(0);
      if (rf_waddr == 5'd3) rf_waddr = 5'd5;
      dm_we = 0;
      if (c == 2) begin rf_we = 1; rf_waddr = 5'd3; rf_wdata = 32'd5; end
      if (c == 20) begin dm_we = 1; dm_addr = TH; dm_wdata = 32'd1; end
      step();
      if (c == 2) chk("watch_x3", watch_value[chan_of(5'd3)*XL +: XL], 32'd5);
      if (c == 20) begin
        chk("pass_at_21", pass, 1'b1);
        chk("done_at_21", done, 1'b1);
      end
    end
    chk("pass_cycles_frozen", cycle_count, 32'd21);

    // Fail: tohost=7.
    do_reset();
    for (int c = 0; c < 5; c++) begin rnd_inputs(0); step(); end
    idle(); dm_we = 1; dm_addr = TH; dm_wdata = 32'd7; step();
    chk("fail_flag", fail, 1'b1);
    chk("fail_code_3", fail_code, 32'd3);
    chk("fail_no_pass", pass, 1'b0);

    // Timeout with no store.
    do_reset();
    for (int c = 0; c < TO + 4; c++) begin
      rnd_inputs(0);
      dm_we = 0;
      step();
      if (c == TO - 2) chk("timeout_not_yet", timeout, 1'b0);
      if (c == TO - 1) chk("timeout_flag", timeout, 1'b1);
    end
    chk("timeout_cycles", cycle_count, 32'(TO));

    // Race: tohost store in the timeout cycle wins.
    do_reset();
    for (int c = 0; c < TO + 2; c++) begin
      rnd_inputs(0);
      dm_we = 0;
      if (c == TO - 1) begin dm_we = 1; dm_addr = TH; dm_wdata = 32'd1; end
      step();
    end
    chk("race_pass", pass, 1'b1);
    chk("race_no_timeout", timeout, 1'b0);

    // x0 filter.
    do_reset();
    trace_ready = 0;
    idle(); rf_we = 1; rf_waddr = 5'd0; rf_wdata = 32'hFFFF_FFFF; step();
    chk("x0_not_traced", trace_valid, 1'b0);
    idle(); rf_we = 1; rf_waddr = 5'd4; rf_wdata = 32'h0000_00A5; step();
    chk("x4_valid", trace_valid, 1'b1);
    chk("x4_addr", trace_addr, 5'd4);
    chk("x4_data", trace_data, 32'h0000_00A5);
    chk("watch_x4", watch_value[chan_of(5'd4)*XL +: XL], 32'h0000_00A5);
    idle(); trace_ready = 1; step(); step();
    chk("x4_single", trace_valid, 1'b0);

    // FIFO stress: 10 writes into depth 8 with the consumer stalled.
    do_reset();
    trace_ready = 0;
    for (int c = 0; c < 10; c++) begin
      idle(); rf_we = 1; rf_waddr = 5'($urandom_range(1, 31)); rf_wdata = $urandom;
      step();
      if (c == 7) chk("no_ovf_at_8", trace_overflow, 1'b0);
    end
    chk("ovf_set", trace_overflow, 1'b1);
    idle(); trace_ready = 1; rf_we = 1; rf_waddr = 5'd9; rf_wdata = $urandom; step();
    chk("full_push_pop", trace_valid, 1'b1);
    idle(); trace_ready = 1;
    for (int c = 0; c < 8; c++) begin
      step();
      if (c == 6) chk("drain_7_left", trace_valid, 1'b1);
    end
    chk("drain_empty", trace_valid, 1'b0);

    // Reset mid-run with entries queued.
    do_reset();
    trace_ready = 0;
    for (int c = 0; c < 9; c++) begin
      idle(); retire = 1;
      if (c < 4) begin rf_we = 1; rf_waddr = 5'(c + 6); rf_wdata = $urandom; end
      step();
    end
    chk("pre_rst_retired", retired_count, 32'd9);
    chk("pre_rst_valid", trace_valid, 1'b1);
    do_reset();
    chk("post_rst_valid", trace_valid, 1'b0);
    chk("post_rst_retired", retired_count, 32'd0);
    chk("post_rst_cycles", cycle_count, 32'd0);

    // Random phase with occasional resets and tohost stores.
    for (int c = 0; c < 500; c++) begin
      rnd_inputs(1);
      rst = ($urandom_range(0, 79) == 0);
      step();
      rst = 0;
    end

    idle(); trace_ready = 1;
    for (int c = 0; c < DEPTH + 4; c++) step();
    chk("final_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
